// File: rtl/multicycle_ctrl.sv
// Multicycle controller for a small RV32I subset (ADDI, ADD, LW, SW, LUI).
// Sequences FETCH/DECODE/EXEC/MEM/WB, traps anything else, and counts retired
// instructions. Strobes are decoded from the current state, so the FETCH and
// MEM handshakes respond to mem_ready in the same cycle.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   FETCH  | read instruction; on mem_ready load IR and bump PC
//   DECODE | classify instr and latch the class
//   EXEC   | single ALU cycle with operand selects for the class
//   MEM    | data access for LW/SW, held until mem_ready
//   WB     | register-file write, then back to FETCH
//   TRAP   | unsupported instruction; parked here until reset
module multicycle_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRW,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  ImmSel,
  output logic        BSel,
  output logic [1:0]  ALUSel,
  output logic        WBSel,
  output logic        RegWEn,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ADDI = 3'd0,
    CLS_ADD  = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_LUI  = 3'd4,
    CLS_BAD  = 3'd5
  } cls_t;

  state_t state_q;
  cls_t   cls_q;
  cls_t   cls_dec;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7            = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign state   = state_q;
  assign illegal = (state_q == TRAP);

  // Classify the instruction register contents into a supported class.
  always_comb begin
    cls_dec = CLS_BAD;
    case (opcode)
      7'b0010011: if (funct3 == 3'b000) cls_dec = CLS_ADDI;
      7'b0110011: if (funct3 == 3'b000 && funct7 == 7'b0000000) cls_dec = CLS_ADD;
      7'b0000011: if (funct3 == 3'b010) cls_dec = CLS_LW;
      7'b0100011: if (funct3 == 3'b010) cls_dec = CLS_SW;
      7'b0110111: cls_dec = CLS_LUI;
      default:    cls_dec = CLS_BAD;
    endcase
  end

  // State sequencing, class latch and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      cls_q   <= CLS_ADDI;
      instret <= 32'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready) state_q <= DECODE;
        end
        DECODE: begin
          cls_q   <= cls_dec;
          state_q <= (cls_dec == CLS_BAD) ? TRAP : EXEC;
        end
        EXEC: begin
          state_q <= (cls_q == CLS_LW || cls_q == CLS_SW) ? MEM : WB;
        end
        MEM: begin
          if (mem_ready) begin
            if (cls_q == CLS_SW) begin
              state_q <= FETCH;
              instret <= instret + 32'd1;
            end else begin
              state_q <= WB;
            end
          end
        end
        WB: begin
          state_q <= FETCH;
          instret <= instret + 32'd1;
        end
        TRAP: begin
          state_q <= TRAP;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // Strobes and datapath selects; reset forces every strobe low.
  always_comb begin
    mem_req = 1'b0;
    MemRW   = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    RegWEn  = 1'b0;
    WBSel   = 1'b0;
    ImmSel  = 2'b00;
    BSel    = 1'b0;
    ALUSel  = 2'b00;

    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      case (cls_q)
        CLS_ADDI: begin ImmSel = 2'b00; BSel = 1'b1; ALUSel = 2'b00; end
        CLS_ADD:  begin ImmSel = 2'b00; BSel = 1'b0; ALUSel = 2'b00; end
        CLS_LW:   begin ImmSel = 2'b01; BSel = 1'b1; ALUSel = 2'b00; end
        CLS_SW:   begin ImmSel = 2'b10; BSel = 1'b1; ALUSel = 2'b00; end
        CLS_LUI:  begin ImmSel = 2'b11; BSel = 1'b1; ALUSel = 2'b01; end
        default:  begin ImmSel = 2'b00; BSel = 1'b0; ALUSel = 2'b00; end
      endcase
    end

    if (state_q == WB) WBSel = (cls_q == CLS_LW);

    if (!RST) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        MEM: begin
          mem_req = 1'b1;
          MemRW   = (cls_q == CLS_SW);
        end
        WB: begin
          RegWEn = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 Ports SHALL be as follows:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  synchronous active-high reset.
- instr  in  32  current instruction-register contents.
- mem_ready  in  1  memory handshake; high means the current access completes this cycle.
- mem_req  out  1  memory access request.
- MemRW  out  1  1 = write (store), 0 = read.
- IRWrite  out  1  load the instruction register from memory.
- PCWrite  out  1  PC <= PC+4.
- ImmSel  out  2  immediate format: 00 = I-ALU, 01 = I-load, 10 = S, 11 = U.
- BSel  out  1  ALU B operand: 1 = immediate, 0 = rs2.
- ALUSel  out  2  00 = add, 01 = pass B; other codes unused.
- WBSel  out  1  writeback source: 0 = ALU, 1 = memory.
- RegWEn  out  1  register-file write enable.
- illegal  out  1  unsupported instruction trapped.
- state  out  3  current FSM state, for debug.
- instret  out  32  retired-instruction count.

Function
REQ-003 The FSM SHALL have these states and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-004 In FETCH, the block SHALL drive mem_req = 1 and MemRW = 0; when mem_ready = 1, it SHALL pulse IRWrite and PCWrite for that one cycle and go to DECODE; otherwise it SHALL hold FETCH with all strobes low.
REQ-005 In DECODE, the block SHALL classify instr and latch the class into an internal register; classes:
- ADDI: opcode 0010011, funct3 000.
- ADD: opcode 0110011, funct3 000, funct7 0000000.
- LW: opcode 0000011, funct3 010.
- SW: opcode 0100011, funct3 010.
- LUI: opcode 0110111.
- Anything else goes to TRAP; every valid class goes to EXEC.
REQ-006 ImmSel, BSel and ALUSel SHALL be driven from the latched class in the EXEC, MEM and WB states:
- ADDI: 00 / 1 / add.
- ADD: xx driven as 00 / 0 / add.
- LW: 01 / 1 / add.
- SW: 10 / 1 / add.
- LUI: 11 / 1 / pass B.
REQ-007 EXEC SHALL last exactly one cycle; LW and SW then go to MEM, and ADDI, ADD and LUI go to WB.
REQ-008 In MEM, the block SHALL drive mem_req = 1, with MemRW = 1 for SW and 0 for LW, and hold until mem_ready = 1; then LW goes to WB and SW goes to FETCH.
REQ-009 WB SHALL last one cycle with RegWEn = 1 and WBSel = 1 for LW (0 otherwise), then go to FETCH.
REQ-010 RegWEn SHALL be asserted only in WB; SW SHALL never assert RegWEn.
REQ-011 instret SHALL increment by 1 on the final cycle of each instruction (the WB cycle, or the SW completing MEM cycle), and SHALL wrap from 0xFFFFFFFF to 0.
REQ-012 In TRAP, the block SHALL hold illegal = 1 with all strobes low and stay in TRAP until RST.
REQ-013 mem_ready SHALL be ignored in DECODE, EXEC, WB and TRAP.
REQ-014 Cycle counts with mem_ready tied to 1 SHALL be:
- ADDI, ADD, LUI: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.

Reset
REQ-015 While RST = 1 at an edge, the block SHALL go to state FETCH, clear the class register to ADDI, and set instret = 0 and illegal = 0.
REQ-016 During reset, all strobes (mem_req, IRWrite, PCWrite, RegWEn, MemRW) SHALL read 0 in the cycle RST is high, overriding FETCH outputs.
REQ-017 RST asserted mid-instruction (including while waiting in MEM) SHALL abandon the instruction with no RegWEn, no instret increment, and a FETCH restart.

Verification
REQ-018 mem_ready = 1; instr = 00300093 (addi) -> states 0,1,2,4,0; ImmSel = 00 and BSel = 1 in EXEC; RegWEn for 1 cycle; instret 0 -> 1.
REQ-019 instr = 00812703 (lw); mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with mem_req = 1 and MemRW = 0; then WB with WBSel = 1 and ImmSel = 01.
REQ-020 instr = 00E12423 (sw) -> MEM asserts MemRW = 1 and ImmSel = 10; no RegWEn; instret increments at MEM exit; next state FETCH.
REQ-021 instr = 00006537 (lui) -> ImmSel = 11, ALUSel = 01; instr = 002081B3 (add) -> BSel = 0, RegWEn in WB.
REQ-022 instr = 0000000F (fence) -> TRAP with illegal = 1 and held; RST pulse -> FETCH with illegal = 0 and instret = 0.
REQ-023 Preload instret = 0xFFFFFFFF via forced state and retire one addi -> instret = 0; RST during MEM of lw -> no RegWEn, state 0 on the next cycle.
